// File: rtl/picorv32_mem_misr_bridge.sv
// picorv32_mem_misr_bridge
//
// Sits directly behind the picorv32 native memory port. Requests go to one
// of three places:
//   * a single-port synchronous RAM (word address = mem_addr[ADDR_W+1:2]),
//   * a two-word MMIO window at 0x4000_0000 holding the MISR control
//     register (0x0) and the current signature (0x4),
//   * anything else: an immediate error response that sets a sticky bus_err.
// Every completed RAM write made while the MISR is enabled is compacted into
// a 32-bit signature.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb   core request (wstrb == 0 is a read)
//   mem_ready, mem_rdata one-cycle response strobe and its read data
//   ram_en/we/addr/wdata RAM request, asserted for one cycle per access
//   ram_rdata            RAM read data, valid the cycle after ram_en
//   misr_en, misr_sig    MISR enable bit and current signature
//   bus_err              sticky out-of-range access flag
//
// Optional build macro MEM_FAULT_INJECT_EN adds inj_enable, inj_period and
// inj_count, and flips one pseudo-random bit of a RAM read response every
// inj_period cycles while enabled. Without the macro read data passes
// through unchanged.
//
// Parameters
//   ADDR_W    RAM word-address width (RAM spans 4*2^ADDR_W bytes)
//   LATENCY   ACCESS wait cycles before the response, 1..15
//   MISR_POLY MISR feedback polynomial
module picorv32_mem_misr_bridge #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              misr_en,
  output logic [31:0]       misr_sig,
  output logic              bus_err
`ifdef MEM_FAULT_INJECT_EN
  ,
  input  logic              inj_enable,
  input  logic [15:0]       inj_period,
  output logic [7:0]        inj_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);
  // 0x4000_0000 >> 3: the window covers exactly two 32-bit words.
  localparam logic [28:0] MMIO_BASE = 29'h0800_0000;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              misr_en_q, misr_en_d;
  logic [31:0]       misr_sig_q, misr_sig_d;
  logic              bus_err_q, bus_err_d;

  logic              in_ram;
  logic              in_mmio;
  logic              is_write;
  logic [31:0]       strb_mask;
  logic [31:0]       misr_step;
  logic [31:0]       flip_mask;

  assign in_ram   = (mem_addr[31:ADDR_W+2] == '0);
  assign in_mmio  = (mem_addr[31:3] == MMIO_BASE);
  assign is_write = |mem_wstrb;

  // Byte-lane mask of the latched write strobes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign strb_mask[gi*8 +: 8] = {8{wstrb_q[gi]}};
  end

  assign misr_step = {misr_sig_q[30:0], 1'b0}
                   ^ (misr_sig_q[31] ? MISR_POLY : 32'h0)
                   ^ ((wdata_q & strb_mask) ^ addr_q);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      rdata_q     <= '0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      misr_en_q   <= 1'b0;
      misr_sig_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      rdata_q     <= rdata_d;
      mem_ready_q <= mem_ready_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      misr_en_q   <= misr_en_d;
      misr_sig_q  <= misr_sig_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          state_d = in_ram ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ram_rd_d    = ram_rd_q;
    ram_wr_d    = ram_wr_q;
    rdata_d     = rdata_q;
    mem_ready_d = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    misr_en_d   = misr_en_q;
    misr_sig_d  = misr_sig_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          wstrb_d  = mem_wstrb;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          rdata_d  = '0;
          if (in_ram) begin
            ram_en_d    = 1'b1;
            ram_we_d    = mem_wstrb;
            ram_addr_d  = mem_addr[ADDR_W+1:2];
            ram_wdata_d = mem_wdata;
            cnt_d       = LAT_INIT;
            ram_rd_d    = ~is_write;
            // Fetches are reads; the instr term only guards against a
            // malformed fetch-with-strobes ever reaching the MISR.
            ram_wr_d    = is_write & ~mem_instr;
          end else if (in_mmio) begin
            mem_ready_d = 1'b1;
            if (is_write) begin
              // Only the control word is writable; bit1 is a self-clearing
              // "clear signature" command and is not stored.
              if (!mem_addr[2] && mem_wstrb[0]) begin
                misr_en_d = mem_wdata[0];
                if (mem_wdata[1]) begin
                  misr_sig_d = '0;
                end
              end
            end else begin
              rdata_d = mem_addr[2] ? misr_sig_q : {31'b0, misr_en_q};
            end
          end else begin
            mem_ready_d = 1'b1;
            bus_err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          mem_ready_d = 1'b1;
        end
      end
      RESP: begin
        if (ram_wr_q && misr_en_q) begin
          misr_sig_d = misr_step;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional read-data fault injection
  // ---------------------------------------------------------------------
`ifdef MEM_FAULT_INJECT_EN
  logic [31:0] rng_q, rng_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  inj_cnt_q, inj_cnt_d;
  logic [31:0] rng_s1;
  logic [31:0] rng_s2;
  logic        inj_tick;
  logic        inj_fire;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rng_q     <= 32'h12345678;
      per_cnt_q <= '0;
      pend_q    <= 1'b0;
      inj_cnt_q <= '0;
    end else begin
      rng_q     <= rng_d;
      per_cnt_q <= per_cnt_d;
      pend_q    <= pend_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end

  always_comb begin
    rng_s1 = rng_q ^ (rng_q << 13);
    rng_s2 = rng_s1 ^ (rng_s1 >> 17);
    rng_d  = rng_s2 ^ (rng_s2 << 5);

    inj_tick  = 1'b0;
    per_cnt_d = per_cnt_q + 16'd1;
    if (!inj_enable || inj_period == 16'd0) begin
      per_cnt_d = '0;
    end else if (per_cnt_q >= inj_period - 16'd1) begin
      per_cnt_d = '0;
      inj_tick  = 1'b1;
    end

    // A tick arms the flip; the next RAM read response consumes it.
    inj_fire  = pend_q && (state_q == RESP) && ram_rd_q;
    pend_d    = (pend_q && !inj_fire) || inj_tick;
    inj_cnt_d = inj_cnt_q;
    if (inj_fire && inj_cnt_q != 8'hFF) begin
      inj_cnt_d = inj_cnt_q + 8'd1;
    end
    flip_mask = inj_fire ? (32'h1 << rng_q[4:0]) : 32'h0;
  end

  assign inj_count = inj_cnt_q;
`else
  assign flip_mask = 32'h0;
`endif

  // RAM read data arrives in the same cycle as the response strobe, so it
  // is forwarded from the RAM's own output register rather than re-timed.
  assign mem_rdata = (mem_ready_q && ram_rd_q) ? (ram_rdata ^ flip_mask) : rdata_q;
  assign mem_ready = mem_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign misr_en   = misr_en_q;
  assign misr_sig  = misr_sig_q;
  assign bus_err   = bus_err_q;

endmodule
